// File: rtl/wam_hit.sv
// wam_hit: synchronises and debounces eight hole buttons, judges presses against the mole mask
// and drains scored hits as isolated one-hot pulses. Optional miss counting under WAM_HIT_MISS_EN.
module wam_hit #(
  parameter int DB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] btn,
  input  logic [7:0] mole,
  output logic [7:0] hit,
  output logic [7:0] whacked,
  output logic       miss,
  output logic [7:0] miss_cnt
);

  localparam int DCW = $clog2(DB_CYCLES);
  localparam logic [DCW-1:0] DC_MAX = DCW'(DB_CYCLES - 1);

  logic [7:0]          s1_r;
  logic [7:0]          s2_r;
  logic [7:0]          db_r;
  logic [7:0]          db_nxt_s;
  logic [7:0][DCW-1:0] dc_r;
  logic [7:0][DCW-1:0] dc_nxt_s;
  logic [7:0]          press_r;
  logic [7:0]          pend_r;
  logic [7:0]          pend_nxt_s;
  logic [7:0]          hit_r;
  logic [7:0]          hit_nxt_s;
  logic [7:0]          whacked_r;
  logic [7:0]          whacked_nxt_s;
  logic [7:0]          strike_s;
  logic [7:0]          grant_s;

  // Per-bit debounce: any disagreement must persist DB_CYCLES cycles; a bounce restarts the count.
  always_comb begin
    db_nxt_s = db_r;
    dc_nxt_s = dc_r;
    for (int i = 0; i < 8; i++) begin
      if (s2_r[i] == db_r[i]) begin
        dc_nxt_s[i] = {DCW{1'b0}};
      end else if (dc_r[i] == DC_MAX) begin
        db_nxt_s[i] = s2_r[i];
        dc_nxt_s[i] = {DCW{1'b0}};
      end else begin
        dc_nxt_s[i] = dc_r[i] + DCW'(1'b1);
      end
    end
  end

  // Judge presses and run the two-phase arbiter; a strike can never hit a bit being granted.
  always_comb begin
    strike_s      = press_r & mole & ~whacked_r;
    whacked_nxt_s = (whacked_r | strike_s) & mole;
    grant_s       = pend_r & (~pend_r + 8'd1);
    if (hit_r != 8'd0) begin
      hit_nxt_s  = 8'd0;
      pend_nxt_s = pend_r | strike_s;
    end else if (pend_r != 8'd0) begin
      hit_nxt_s  = grant_s;
      pend_nxt_s = (pend_r & ~grant_s) | strike_s;
    end else begin
      hit_nxt_s  = 8'd0;
      pend_nxt_s = strike_s;
    end
  end

  // Main pipeline registers: synchroniser, debounce, press detect, pending/whacked, hit.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s1_r      <= 8'd0;
      s2_r      <= 8'd0;
      db_r      <= 8'd0;
      dc_r      <= '0;
      press_r   <= 8'd0;
      pend_r    <= 8'd0;
      whacked_r <= 8'd0;
      hit_r     <= 8'd0;
    end else begin
      s1_r      <= btn;
      s2_r      <= s1_r;
      db_r      <= db_nxt_s;
      dc_r      <= dc_nxt_s;
      press_r   <= db_nxt_s & ~db_r;
      pend_r    <= pend_nxt_s;
      whacked_r <= whacked_nxt_s;
      hit_r     <= hit_nxt_s;
    end
  end

  assign hit     = hit_r;
  assign whacked = whacked_r;

`ifdef WAM_HIT_MISS_EN
  logic       stray_s;
  logic       miss_r;
  logic [7:0] miss_cnt_r;

  assign stray_s = |(press_r & ~mole);

  // Miss pulse and saturating miss count; several stray presses in one cycle count once.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      miss_r     <= 1'b0;
      miss_cnt_r <= 8'd0;
    end else begin
      miss_r <= stray_s;
      if (stray_s && (miss_cnt_r != 8'd255)) begin
        miss_cnt_r <= miss_cnt_r + 8'd1;
      end else begin
        miss_cnt_r <= miss_cnt_r;
      end
    end
  end

  assign miss     = miss_r;
  assign miss_cnt = miss_cnt_r;
`else
  assign miss     = 1'b0;
  assign miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_wam_hit.sv
// Scoreboard bench for wam_hit with DB_CYCLES=4: stimulus queues expected hit pulses and
// level checks by cycle; a negedge monitor pops and compares them.
module tb_wam_hit;

`ifdef WAM_HIT_MISS_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  localparam int S_HIT = 0;
  localparam int S_WHK = 1;
  localparam int S_MISS = 2;
  localparam int S_MCNT = 3;

  typedef struct { int c; logic [7:0] v; } hit_t;
  typedef struct { int c; int sig; logic [7:0] v; } lvl_t;

  logic       clk;
  logic       clr_n;
  logic [7:0] btn;
  logic [7:0] mole;
  logic [7:0] hit;
  logic [7:0] whacked;
  logic       miss;
  logic [7:0] miss_cnt;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miscmp = 0;
  bit   done = 1'b0;
  logic [7:0] prev_hit = 8'd0;
  hit_t exp_q[$];
  lvl_t lvl_q[$];

  wam_hit #(.DB_CYCLES(4)) dut (
    .clk(clk), .clr_n(clr_n), .btn(btn), .mole(mole),
    .hit(hit), .whacked(whacked), .miss(miss), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sname(input int s);
    case (s)
      S_HIT:   return "hit";
      S_WHK:   return "whacked";
      S_MISS:  return "miss";
      S_MCNT:  return "miss_cnt";
      default: return "unknown";
    endcase
  endfunction

  task automatic go(input int t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t);
  endtask

  task automatic wait_n(input int n);
    go(cyc + n);
  endtask

  task automatic push_hit(input logic [7:0] v, input int c);
    hit_t e;
    e.c = c;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic push_lvl(input int sig, input int c, input logic [7:0] v);
    lvl_t e;
    e.c = c;
    e.sig = sig;
    e.v = v;
    lvl_q.push_back(e);
  endtask

  // Monitor: compares scheduled levels and every nonzero hit against the scoreboard.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int i = lvl_q.size() - 1; i >= 0; i--) begin
        if (lvl_q[i].c == cyc) begin
          logic [7:0] act;
          case (lvl_q[i].sig)
            S_HIT:   act = hit;
            S_WHK:   act = whacked;
            S_MISS:  act = {7'd0, miss};
            S_MCNT:  act = miss_cnt;
            default: act = 8'hxx;
          endcase
          n_vec++;
          if (act !== lvl_q[i].v) begin
            n_miscmp++;
            $display("FAIL %s cyc=%0d got=%h want=%h", sname(lvl_q[i].sig), cyc, act, lvl_q[i].v);
          end
          lvl_q.delete(i);
        end
      end
      if (hit !== 8'd0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miscmp++;
          $display("FAIL unexpected_hit cyc=%0d got=%h want=none", cyc, hit);
        end else begin
          hit_t e;
          e = exp_q.pop_front();
          if ((hit !== e.v) || (cyc != e.c)) begin
            n_miscmp++;
            $display("FAIL hit_pulse got=%h@%0d want=%h@%0d", hit, cyc, e.v, e.c);
          end
        end
        if (prev_hit !== 8'd0) begin
          n_miscmp++;
          $display("FAIL hit_gap cyc=%0d got=%h after %h want=00", cyc, hit, prev_hit);
        end
      end
      prev_hit = hit;
      if (cyc > 20000) begin
        n_miscmp++;
        $display("FAIL timeout cyc=%0d got=running want=done", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
      end
      if (done) begin
        n_vec++;
        if ((exp_q.size() != 0) || (lvl_q.size() != 0)) begin
          n_miscmp++;
          $display("FAIL leftover got=%0d hits,%0d levels want=0,0", exp_q.size(), lvl_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
      end
    end
  end

  initial begin
    int n;
    int m;
    clr_n = 1'b0;
    btn   = 8'd0;
    mole  = 8'd0;

    // Reset state
    go(2);
    push_lvl(S_HIT, 3, 8'h00);
    push_lvl(S_WHK, 3, 8'h00);
    push_lvl(S_MISS, 3, 8'h00);
    push_lvl(S_MCNT, 3, 8'h00);
    go(4);
    clr_n = 1'b1;
    wait_n(4);

    // Clean press on hole 2
    n = cyc;
    mole = 8'h04;
    btn  = 8'h04;
    push_lvl(S_WHK, n + 6, 8'h00);
    push_lvl(S_WHK, n + 7, 8'h04);
    push_hit(8'h04, n + 8);
    push_lvl(S_WHK, n + 12, 8'h04);
    go(n + 14);
    m = cyc;
    btn  = 8'h00;
    mole = 8'h00;
    push_lvl(S_WHK, m, 8'h04);
    push_lvl(S_WHK, m + 1, 8'h00);
    wait_n(12);

    // Bouncing press on hole 5
    n = cyc;
    mole = 8'h20;
    btn = 8'h20; wait_n(1);
    btn = 8'h00; wait_n(1);
    btn = 8'h20; wait_n(1);
    btn = 8'h00; wait_n(1);
    btn = 8'h20;
    push_lvl(S_WHK, n + 11, 8'h20);
    push_hit(8'h20, n + 12);
    go(n + 16);
    btn = 8'h00;
    wait_n(8);
    mole = 8'h00;
    push_lvl(S_WHK, cyc + 1, 8'h00);
    wait_n(4);

    // Simultaneous presses drain lowest first, every other cycle
    n = cyc;
    mole = 8'hFF;
    btn  = 8'hA5;
    push_lvl(S_WHK, n + 7, 8'hA5);
    push_hit(8'h01, n + 8);
    push_hit(8'h04, n + 10);
    push_hit(8'h20, n + 12);
    push_hit(8'h80, n + 14);
    push_lvl(S_WHK, n + 15, 8'hA5);
    go(n + 16);
    btn = 8'h00;
    wait_n(8);
    mole = 8'h00;
    push_lvl(S_WHK, cyc + 1, 8'h00);
    wait_n(4);

    // Re-press on hole 3: second press ignored until the mole reappears
    n = cyc;
    mole = 8'h08;
    btn  = 8'h08;
    push_hit(8'h08, n + 8);
    go(n + 10);
    btn = 8'h00;
    wait_n(10);
    n = cyc;
    btn = 8'h08;
    push_lvl(S_WHK, n + 8, 8'h08);
    go(n + 10);
    btn = 8'h00;
    wait_n(10);
    n = cyc;
    mole = 8'h00;
    push_lvl(S_WHK, n + 1, 8'h00);
    wait_n(1);
    mole = 8'h08;
    wait_n(2);
    n = cyc;
    btn = 8'h08;
    push_lvl(S_WHK, n + 7, 8'h08);
    push_hit(8'h08, n + 8);
    go(n + 10);
    btn = 8'h00;
    wait_n(10);
    mole = 8'h00;
    push_lvl(S_MCNT, cyc + 1, 8'h00);
    wait_n(4);

    // Presses at an empty hole
    n = cyc;
    btn = 8'h01;
    push_lvl(S_MISS, n + 6, 8'h00);
    push_lvl(S_MISS, n + 7, MEN ? 8'h01 : 8'h00);
    push_lvl(S_MCNT, n + 7, MEN ? 8'h01 : 8'h00);
    push_lvl(S_MISS, n + 8, 8'h00);
    go(n + 7);
    btn = 8'h00;
    go(n + 16);
    for (int k = 0; k < 2; k++) begin
      n = cyc;
      btn = 8'h01;
      go(n + 7);
      btn = 8'h00;
      go(n + 16);
    end
    push_lvl(S_MCNT, cyc + 1, MEN ? 8'd3 : 8'd0);
    push_lvl(S_WHK, cyc + 1, 8'h00);
    wait_n(2);
    for (int k = 0; k < 257; k++) begin
      n = cyc;
      btn = 8'h01;
      go(n + 7);
      btn = 8'h00;
      go(n + 16);
    end
    push_lvl(S_MCNT, cyc + 1, MEN ? 8'd255 : 8'd0);
    wait_n(2);

    // Reset between pulses of an eight-way drain discards everything
    n = cyc;
    mole = 8'hFF;
    btn  = 8'hFF;
    push_lvl(S_WHK, n + 8, 8'hFF);
    push_hit(8'h01, n + 8);
    go(n + 8);
    clr_n = 1'b0;
    btn   = 8'h00;
    go(n + 9);
    clr_n = 1'b1;
    push_lvl(S_HIT, n + 9, 8'h00);
    push_lvl(S_WHK, n + 9, 8'h00);
    push_lvl(S_MISS, n + 9, 8'h00);
    push_lvl(S_MCNT, n + 9, 8'h00);
    push_lvl(S_WHK, n + 40, 8'h00);
    go(n + 45);
    done = 1'b1;
  end

endmodule

// File: doc/wam_hit.md
# wam_hit

Hit judge for the whack-a-mole game: synchronises and debounces the eight raw hole buttons and compares each debounced press against the current mole mask. It produces the one-hot `hit[7:0]` pulses consumed by the score counter, plus a per-hole whacked mask that tells the mole generator to hide a struck mole. The score counter is edge-triggered on the OR of `hit`, so this block guarantees every scored hit is a distinct 1-cycle pulse separated by at least one idle cycle.

## Interface
- `DB_CYCLES`, 250000: consecutive cycles a synchronised button must disagree with its debounced state before that state flips (5 ms at 50 MHz). Minimum 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `clr_n`  in  1  synchronous, active-low reset.
- `btn`  in  8  raw hole buttons, asynchronous, active-high.
- `mole`  in  8  current mole mask from the mole generator, synchronous to `clk`.
- `hit`  out  8  one-hot, 1-cycle scored-hit pulse; all zero when idle.
- `whacked`  out  8  level; bit i is set while mole i has been struck in its current appearance.
- `miss`  out  1  1-cycle pulse on a press at an empty hole (only with `WAM_HIT_MISS_EN`).
- `miss_cnt`  out  8  saturating miss count (only with `WAM_HIT_MISS_EN`).

## Operation
- Synchroniser: two flops per bit; `s2[i]` is the synchronised button.
- Debounce, per bit: state `db[i]` and counter `dc[i]` (width `$clog2(DB_CYCLES)`).
  - If `s2[i]==db[i]`, then `dc[i]<=0`.
  - Otherwise, if `dc[i]==DB_CYCLES-1`, then `db[i]<=s2[i]` and `dc[i]<=0`.
  - Otherwise `dc[i]<=dc[i]+1`.
  - Any bounce resets the count.
- Press detect: `press[i]` is registered high for 1 cycle after `db[i]` rises. Releases are ignored.
- Judge, evaluated in the cycle `press[i]` is high, using `mole[i]` sampled in that cycle:
  - `mole[i]=1` and `whacked[i]=0`: set `pend[i]` and `whacked[i]`.
  - `mole[i]=1` and `whacked[i]=1`: press ignored.
  - `mole[i]=0`: miss event.
- `whacked[i]` clears in any cycle `mole[i]==0`.
  - A set and a clear cannot coincide, because a set requires `mole[i]=1`.
- Output arbiter, two-phase:
  - If `hit!=0` this cycle, `hit<=0` next edge (enforced gap).
  - Else if `pend!=0`, `hit<=` onehot of the lowest set `pend` bit, and that bit clears.
  - Else `hit<=0`.
- A pending hit is delivered even if its mole has since disappeared; the point was earned at press time.
- Simultaneous presses on several holes: all are judged in the same cycle and all pending bits set. They then drain lowest index first, one every 2 cycles, so 8 simultaneous hits take 16 cycles.
- `pend[i]` cannot double-set: a second press requires `whacked[i]` to have cleared, which requires the mole to go away and return. Within the ≥`DB_CYCLES` press spacing, `pend[i]` always drains first.

## Timing
- Reset (`clr_n` low at an edge) clears all state on that edge: synchronisers, `db`, `dc`, `press`, `pend`, `whacked`, `hit`, `miss`, `miss_cnt`.
  - All outputs read 0 from that edge on, including mid-debounce or with hits pending. Pending hits are discarded.
- Latency, button held clean from an edge to a `hit` pulse, no backlog: `DB_CYCLES+4` cycles.
  - 2 cycles synchroniser.
  - `DB_CYCLES` cycles debounce.
  - 1 cycle press/judge register.
  - 1 cycle arbiter.
- `whacked[i]` rises 1 cycle before the corresponding `hit` pulse when there is no backlog.
- `miss` pulses 1 cycle after `press[i]` (same stage as `pend` set).
- `hit` is never high in two consecutive cycles.

## Configuration
- `WAM_HIT_MISS_EN` defined:
  - A miss event pulses `miss` for 1 cycle and increments `miss_cnt`.
  - `miss_cnt` saturates at 255; multiple misses in one cycle count as one.
- `WAM_HIT_MISS_EN` undefined:
  - Miss logic is not built; `miss` and `miss_cnt` are tied to 0.
  - Presses on empty holes are silently ignored.

## Test plan
All scenarios use `DB_CYCLES=4`.
- Clean press: `mole=8'h04`, `btn[2]` raised and held → `hit=8'h04` for exactly 1 cycle, 8 cycles after the raise; `whacked=8'h04` one cycle earlier. It stays set until `mole[2]` drops, then clears the next cycle.
- Bounce: `btn[5]` toggles 1,0,1,0 per cycle then holds 1, with `mole=8'h20` → exactly one `hit=8'h20`, issued 8 cycles after the final rise.
- Simultaneous: `mole=8'hFF`, `btn=8'hA5` raised together → `hit` sequence `01,00,04,00,20,00,80,00`; `whacked=8'hA5`.
- Re-press: press hole 3 twice while `mole[3]` stays 1 → one hit only. Drop `mole[3]` for 1 cycle, raise it again, press → second hit.
- Miss (with macro): `mole=0`, press hole 0 three times → three `miss` pulses, `miss_cnt=3`, `hit` never nonzero. 260 misses → `miss_cnt=255`.
- Reset mid-drain: `clr_n` low for 1 cycle between `hit` pulses of the 8-way case → `hit`, `pend`, `whacked` all 0 afterwards; no further pulses.
